data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Data-memory controller directly downstream of the load/store byte-lane wrapper.
//  Takes lane-aligned store data plus the byte mask, or a load request, and owns a word-wide SRAM
//  of 2**AddrWidth words with byte-enable writes and a configurable read latency.
//  Returns the raw word and data_valid back to the wrapper. Drives stall to freeze the core pipeline
//  while a load is outstanding.
// PARAMETERS
//  DataWidth  32  word width; must be 32 (4 byte lanes)
//  AddrWidth  10  word-address bits; memory depth = 2**AddrWidth words
//  Latency    2   load latency in cycles from accept to data_valid; legal range 1..4
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          asynchronous reset, active low
//  mem_en      in   1          store request
//  Load        in   1          load request
//  addr        in   DataWidth  byte address; [1:0] ignored (lanes already placed upstream)
//  masking     in   4          byte-lane write enables for stores
//  data_i      in   DataWidth  lane-aligned store data
//  stall       out  1          core must hold its request and pipeline while high
//  data_valid  out  1          one-cycle pulse: load word valid on rdata
//  rdata       out  DataWidth  raw loaded word, fed to the wrapper's load input
//  err         out  1          one-cycle pulse: access was out of range
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE; stall=0, data_valid=0, rdata=0, err=0; latency counter and latched address cleared.
//   - Memory contents are NOT cleared.
//   - Reset mid-load aborts the load with no data_valid.
//  Address decode
//   - word index = addr[AddrWidth+1:2].
//   - Access is out of range if any of addr[DataWidth-1:AddrWidth+2] is 1.
//  FSM states: IDLE, WAIT, RESP
//   - IDLE, mem_en=1: store accepted. Each lane i with masking[i]=1 writes data_i[8i+7:8i] at the next edge.
//     - stall stays 0; state stays IDLE.
//     - masking=0000 writes nothing.
//     - Out-of-range store: write suppressed; err=1 the following cycle.
//   - IDLE, Load=1 and mem_en=0: load accepted. Word index and range flag are latched; counter loaded with Latency-1.
//     - stall=1 combinationally in the accept cycle.
//     - Next state is WAIT if Latency>1, else RESP.
//   - IDLE, mem_en=1 and Load=1: store wins; the load is ignored (no stall, no data_valid).
//   - WAIT: stall=1; counter decrements each cycle; go to RESP when counter reaches 1.
//     - mem_en/Load are ignored in WAIT.
//   - RESP (one cycle): data_valid=1, rdata = word read at the latched index, stall=0; err=1 if out of range.
//     - Out-of-range load returns rdata=0.
//     - Requests are ignored in RESP; next state IDLE.
//   - rdata holds its last value when data_valid=0.
//  Timing
//   - Load accepted in cycle 0 gives data_valid in cycle Latency; stall is high in cycles 0..Latency-1.
//   - Store accepted in cycle n followed by a load to the same word in cycle n+1 returns the new data (write-before-read).
//   - Back-to-back loads: the earliest second accept is the cycle after RESP.
//  Counter is ceil(log2(Latency+1)) bits. No wrap-around: the index is bounded by AddrWidth.
// TESTING
//  1 Reset: assert rst_n=0 mid-WAIT -> stall=0, data_valid=0, rdata=0 immediately; no data_valid after release.
//  2 SW 0xDEADBEEF @0x10, masking=1111; LW @0x10 (Latency=2)
//    -> stall=1 for cycles 0,1; data_valid=1, rdata=0xDEADBEEF in cycle 2.
//  3 Word 0x0 @0x20; SB with masking=0100, data_i=0x00AB0000; LW @0x20 -> rdata=0x00AB0000.
//    Then SH with masking=0011, data_i=0x00001234 -> next LW rdata=0x00AB1234.
//  4 Out of range (AddrWidth=10): SW @0x1000 -> err pulses, memory unchanged;
//    LW @0x1000 -> data_valid with rdata=0 and err=1 in the same cycle.
//  5 mem_en=1 and Load=1 together @0x30 -> store performed, no stall, no data_valid.
//    SW @0x40 in cycle n, LW @0x40 in cycle n+1 -> new data returned.
//  6 Latency=1 and Latency=4 builds: LW -> data_valid in cycles 1 and 4 resp.; stall high for exactly 1 and 4 cycles.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Bus between the load/store byte-lane wrapper (master) and the data-memory
// controller (slave).
//   mem_en, Load     : store / load request strobes from the wrapper
//   addr             : byte address, low two bits unused (lanes already placed)
//   masking, data_i  : byte-lane write enables and lane-aligned store data
//   stall            : freeze request for the core pipeline while a load is in flight
//   data_valid, rdata: one-cycle load response and the raw loaded word
//   err              : one-cycle pulse flagging an out-of-range access
interface data_mem_ctrl_if #(
  parameter int DataWidth = 32
);
  logic                 mem_en;
  logic                 Load;
  logic [DataWidth-1:0] addr;
  logic [3:0]           masking;
  logic [DataWidth-1:0] data_i;
  logic                 stall;
  logic                 data_valid;
  logic [DataWidth-1:0] rdata;
  logic                 err;

  modport master (
    output mem_en, Load, addr, masking, data_i,
    input  stall, data_valid, rdata, err
  );

  modport slave (
    input  mem_en, Load, addr, masking, data_i,
    output stall, data_valid, rdata, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller sitting directly behind the load/store byte-lane
// wrapper. Owns a 2**AddrWidth-word SRAM with per-byte write enables.
// Stores complete in a single cycle without stalling; loads stall the core
// and return the raw word with a one-cycle data_valid pulse Latency cycles
// after being accepted.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   bus   : slave side of data_mem_ctrl_if (requests in, stall/response out)
// Parameters:
//   DataWidth : word width, four byte lanes (32)
//   AddrWidth : word-address bits
//   Latency   : load accept to data_valid distance in cycles (1..4)
module data_mem_ctrl #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10,
  parameter int Latency   = 2
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int Depth = 2 ** AddrWidth;
  localparam int Lanes = DataWidth / 8;
  localparam int CntW  = $clog2(Latency + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(Latency - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [AddrWidth-1:0]   idx_q, idx_d;
  logic                   oor_q, oor_d;
  logic                   data_valid_q, data_valid_d;
  logic                   err_q, err_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;

  logic [DataWidth-1:0]   mem [Depth];

  logic [AddrWidth-1:0]   req_idx;
  logic                   req_oor;
  logic                   store_acc;
  logic                   load_acc;
  logic                   rsp_go;
  logic [AddrWidth-1:0]   rd_idx;
  logic                   rd_oor;
  logic                   addr_unused;

  // Any set bit above the word-index field means the access misses the SRAM.
  assign req_idx     = bus.addr[AddrWidth+1:2];
  assign req_oor     = |bus.addr[DataWidth-1:AddrWidth+2];
  assign addr_unused = ^bus.addr[1:0];

  // A store always beats a simultaneous load request.
  assign store_acc = (state_q == IDLE) && bus.mem_en;
  assign load_acc  = (state_q == IDLE) && bus.Load && !bus.mem_en;

  // The accept cycle stalls combinationally so the core freezes immediately.
  assign bus.stall      = load_acc || (state_q == WAIT);
  assign bus.data_valid = data_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    oor_d        = oor_q;
    data_valid_d = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    rsp_go       = 1'b0;
    rd_idx       = idx_q;
    rd_oor       = oor_q;
    unique case (state_q)
      IDLE: begin
        if (store_acc) begin
          err_d = req_oor;
        end else if (load_acc) begin
          idx_d  = req_idx;
          oor_d  = req_oor;
          cnt_d  = CntLoad;
          rd_idx = req_idx;
          rd_oor = req_oor;
          if (Latency > 1) begin
            state_d = WAIT;
          end else begin
            rsp_go = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          rsp_go = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The response is captured on the edge entering RESP so that rdata,
    // data_valid and err all come straight from flops during RESP.
    if (rsp_go) begin
      state_d      = RESP;
      data_valid_d = 1'b1;
      err_d        = rd_oor;
      rdata_d      = rd_oor ? '0 : mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      oor_q        <= 1'b0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      oor_q        <= oor_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Memory array has no reset; out-of-range stores are dropped here.
  always_ff @(posedge clk) begin
    if (store_acc && !req_oor) begin
      for (int i = 0; i < Lanes; i++) begin
        if (bus.masking[i]) begin
          mem[req_idx][8*i +: 8] <= bus.data_i[8*i +: 8];
        end
      end
    end
  end

endmodule
